decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 56 +++++
 rtl/pending_scoreboard.sv | 62 ++++++
 rtl/decode_stage.sv | 154 +++++++++++++++
 tb/tb_decode_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, control bundle and control table.
// Imported by the decode stage and its scoreboard.
package decode_pkg;

    localparam logic [3:0] OP_LW   = 4'h0;
    localparam logic [3:0] OP_SW   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_INV  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_ANDI = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_ORI  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'h9;
    localparam logic [3:0] OP_SLL  = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_CLR  = 4'hD;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src1;
        logic       alu_src2;
        logic       mem_write;
        logic       mem_to_reg;
        logic       use_rs;
        logic       use_rt;
        logic       illegal;
    } ctrl_t;

    // Columns: alu_op dst wr s1 s2 mw m2r urs urt ill
    function automatic ctrl_t decode_ctrl(input logic [3:0] op);
        ctrl_t c;
        case (op)
            OP_LW:   c = 12'b000_0_1_0_1_0_1_1_0_0;
            OP_SW:   c = 12'b000_0_0_0_1_1_0_1_1_0;
            OP_ADD:  c = 12'b000_1_1_0_0_0_0_1_1_0;
            OP_ADDI: c = 12'b000_0_1_0_1_0_0_1_0_0;
            OP_INV:  c = 12'b001_1_1_0_0_0_0_1_0_0;
            OP_AND:  c = 12'b010_1_1_0_0_0_0_1_1_0;
            OP_ANDI: c = 12'b010_0_1_0_1_0_0_1_0_0;
            OP_OR:   c = 12'b011_1_1_0_0_0_0_1_1_0;
            OP_ORI:  c = 12'b011_0_1_0_1_0_0_1_0_0;
            OP_SRA:  c = 12'b100_0_1_0_1_0_0_1_0_0;
            OP_SLL:  c = 12'b101_0_1_0_1_0_0_1_0_0;
            OP_BEQ:  c = 12'b110_0_0_0_0_0_0_1_1_0;
            OP_BNE:  c = 12'b111_0_0_0_0_0_0_1_1_0;
            OP_CLR:  c = 12'b010_1_1_1_0_0_0_0_0_0;
            default: c = 12'b000_0_0_0_0_0_0_0_0_1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pending_scoreboard.sv
// Per-register count of dispatched but not yet retired writes.
// Query ports report counts after this cycle's retirement.
module pending_scoreboard
    import decode_pkg::*;
#(
    parameter int RADDR_W      = 2,
    parameter int MAX_INFLIGHT = 3,
    localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc_i,
    input  logic [RADDR_W-1:0] inc_addr_i,
    input  logic               dec_i,
    input  logic [RADDR_W-1:0] dec_addr_i,
    input  logic [RADDR_W-1:0] rs_addr_i,
    input  logic [RADDR_W-1:0] rt_addr_i,
    input  logic [RADDR_W-1:0] dst_addr_i,
    output logic [CW-1:0]      rs_cnt_o,
    output logic [CW-1:0]      rt_cnt_o,
    output logic [CW-1:0]      dst_cnt_o
);

    localparam int NREG = 1 << RADDR_W;
    localparam logic [CW-1:0] MAXC = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic [CW-1:0] avail [NREG];

    // Next counts: retire without wrap, dispatch saturates, both cancel.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            avail[i] = cnt_q[i];
            cnt_d[i] = cnt_q[i];
            if (dec_i && dec_addr_i == RADDR_W'(i) && cnt_q[i] != '0)
                avail[i] = cnt_q[i] - ONE;
            if (inc_i && inc_addr_i == RADDR_W'(i)) begin
                if (!(dec_i && dec_addr_i == RADDR_W'(i))
                    && cnt_q[i] != MAXC)
                    cnt_d[i] = cnt_q[i] + ONE;
            end else begin
                cnt_d[i] = avail[i];
            end
        end
    end

    assign rs_cnt_o  = avail[rs_addr_i];
    assign rt_cnt_o  = avail[rt_addr_i];
    assign dst_cnt_o = avail[dst_addr_i];

    // Counter state, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: control decode, hazard check against pending writes,
// and a single valid/ready output register.
module decode_stage
    import decode_pkg::*;
#(
    parameter int RADDR_W      = 2,
    parameter int IMM_W        = 8,
    parameter int MAX_INFLIGHT = 3,
    localparam int INSTR_W     = 4 + 2 * RADDR_W + IMM_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    input  logic               wb_valid,
    input  logic [RADDR_W-1:0] wb_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_opcode,
    output logic [RADDR_W-1:0] out_rs,
    output logic [RADDR_W-1:0] out_rt,
    output logic [RADDR_W-1:0] out_dst,
    output logic [IMM_W-1:0]   out_imm,
    output logic [2:0]         out_alu_op,
    output logic               out_reg_write,
    output logic               out_alu_src1,
    output logic               out_alu_src2,
    output logic               out_mem_write,
    output logic               out_mem_to_reg,
    output logic               out_illegal,
    output logic               stall
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW:0] MAXC = (CW + 1)'(MAX_INFLIGHT);

    logic [3:0]         op;
    logic [RADDR_W-1:0] rs, rt, rd, dst;
    logic [IMM_W-1:0]   imm;
    ctrl_t              ctrl;

    logic               valid_q, valid_d;
    logic [3:0]         opcode_q;
    logic [RADDR_W-1:0] rs_q, rt_q, dst_q;
    logic [IMM_W-1:0]   imm_q;
    logic [2:0]         alu_op_q;
    logic               reg_write_q, src1_q, src2_q;
    logic               mem_write_q, mem_to_reg_q, illegal_q;

    logic [CW-1:0]      rs_cnt, rt_cnt, dst_cnt;
    logic [CW:0]        dst_eff;
    logic               held_w, dispatch, capture, hazard;
    logic               haz_rs, haz_rt, haz_dst;

    assign op   = in_instr[INSTR_W-1 -: 4];
    assign rs   = in_instr[IMM_W+2*RADDR_W-1 -: RADDR_W];
    assign rt   = in_instr[IMM_W+RADDR_W-1 -: RADDR_W];
    assign imm  = in_instr[IMM_W-1:0];
    assign rd   = imm[IMM_W-1 -: RADDR_W];
    assign ctrl = decode_ctrl(op);
    assign dst  = ctrl.reg_dst ? rd : rt;

    assign held_w   = valid_q && reg_write_q;
    assign dispatch = valid_q && out_ready && !flush && !rst;

    // A destination may carry up to MAX_INFLIGHT outstanding writes; a
    // held write leaving this cycle is counted now so the cap holds.
    assign dst_eff = {1'b0, dst_cnt}
                   + {{CW{1'b0}}, held_w && dispatch && dst_q == dst};

    assign haz_rs = ctrl.use_rs
        && (rs_cnt != '0 || (held_w && !dispatch && dst_q == rs));
    assign haz_rt = ctrl.use_rt
        && (rt_cnt != '0 || (held_w && !dispatch && dst_q == rt));
    assign haz_dst = ctrl.reg_write
        && ((held_w && !dispatch && dst_q == dst) || dst_eff >= MAXC);

    assign hazard   = !rst && (haz_rs || haz_rt || haz_dst);
    assign in_ready = !rst && (!valid_q || out_ready) && !hazard && !flush;
    assign stall    = in_valid && hazard;
    assign capture  = in_valid && in_ready;
    assign valid_d  = capture ? 1'b1
                    : (dispatch || flush) ? 1'b0 : valid_q;

    pending_scoreboard #(
        .RADDR_W      (RADDR_W),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (dispatch && reg_write_q),
        .inc_addr_i (dst_q),
        .dec_i      (wb_valid),
        .dec_addr_i (wb_addr),
        .rs_addr_i  (rs),
        .rt_addr_i  (rt),
        .dst_addr_i (dst),
        .rs_cnt_o   (rs_cnt),
        .rt_cnt_o   (rt_cnt),
        .dst_cnt_o  (dst_cnt)
    );

    // Output register: load on capture, hold until dispatch or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            opcode_q     <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            dst_q        <= '0;
            imm_q        <= '0;
            alu_op_q     <= '0;
            reg_write_q  <= 1'b0;
            src1_q       <= 1'b0;
            src2_q       <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (capture) begin
                opcode_q     <= op;
                rs_q         <= rs;
                rt_q         <= rt;
                dst_q        <= dst;
                imm_q        <= imm;
                alu_op_q     <= ctrl.alu_op;
                reg_write_q  <= ctrl.reg_write;
                src1_q       <= ctrl.alu_src1;
                src2_q       <= ctrl.alu_src2;
                mem_write_q  <= ctrl.mem_write;
                mem_to_reg_q <= ctrl.mem_to_reg;
                illegal_q    <= ctrl.illegal;
            end
        end
    end

    assign out_valid      = valid_q;
    assign out_opcode     = opcode_q;
    assign out_rs         = rs_q;
    assign out_rt         = rt_q;
    assign out_dst        = dst_q;
    assign out_imm        = imm_q;
    assign out_alu_op     = alu_op_q;
    assign out_reg_write  = reg_write_q;
    assign out_alu_src1   = src1_q;
    assign out_alu_src2   = src2_q;
    assign out_mem_write  = mem_write_q;
    assign out_mem_to_reg = mem_to_reg_q;
    assign out_illegal    = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: opcode table sweep plus hazard, flush and
// reset sequences, with a queue of expected output bundles.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, wb_valid, out_ready;
    logic [15:0] in_instr;
    logic [1:0]  wb_addr;
    logic        in_ready, out_valid, stall;
    logic [3:0]  out_opcode;
    logic [1:0]  out_rs, out_rt, out_dst;
    logic [7:0]  out_imm;
    logic [2:0]  out_alu_op;
    logic        out_reg_write, out_alu_src1, out_alu_src2;
    logic        out_mem_write, out_mem_to_reg, out_illegal;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
        .out_dst(out_dst), .out_imm(out_imm), .out_alu_op(out_alu_op),
        .out_reg_write(out_reg_write), .out_alu_src1(out_alu_src1),
        .out_alu_src2(out_alu_src2), .out_mem_write(out_mem_write),
        .out_mem_to_reg(out_mem_to_reg), .out_illegal(out_illegal),
        .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  alu;
        logic        rd, rw, s1, s2, mw, m2r, ill;
    } vec_t;

    vec_t        vec [16];
    logic [26:0] q [$];
    logic [26:0] exp_b;
    logic [26:0] out_b;
    int          errs = 0;
    int          checks = 0;

    assign out_b = {out_opcode, out_rs, out_rt, out_dst, out_imm,
                    out_alu_op, out_reg_write, out_alu_src1, out_alu_src2,
                    out_mem_write, out_mem_to_reg, out_illegal};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv,
                     $time);
        end
    endtask

    task automatic chk_cnt(input string nm, input int r, input int e);
        logic [1:0] c;
        c = dut.u_sb.cnt_q[r];
        chk(nm, 32'(c), 32'(e));
    endtask

    function automatic logic [26:0] exp_bundle(input logic [15:0] ins);
        vec_t       v;
        logic [1:0] d;
        v = vec[ins[15:12]];
        d = v.rd ? ins[7:6] : ins[9:8];
        return {ins[15:12], ins[11:10], ins[9:8], d, ins[7:0], v.alu,
                v.rw, v.s1, v.s2, v.mw, v.m2r, v.ill};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] ins, input int budget);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_instr = ins;
        @(negedge clk);
        while (!in_ready && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("send_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wb(input logic [1:0] a);
        wb_valid = 1'b1;
        wb_addr  = a;
        tick();
        wb_valid = 1'b0;
    endtask

    // Scoreboard: expected bundles pushed on capture, popped on leave.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && (out_ready || flush)) begin
                if (q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL sb_unexpected: got %h want none", out_b);
                end else begin
                    exp_b = q.pop_front();
                    chk("bundle", 32'(out_b), 32'(exp_b));
                end
            end
            if (in_valid && in_ready) q.push_back(exp_bundle(in_instr));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // instr = {op, rs=0, rt=1, imm=A5 -> rd=2}
        vec[0]  = '{16'h01A5, 3'b000, 0, 1, 0, 1, 0, 1, 0};
        vec[1]  = '{16'h11A5, 3'b000, 0, 0, 0, 1, 1, 0, 0};
        vec[2]  = '{16'h21A5, 3'b000, 1, 1, 0, 0, 0, 0, 0};
        vec[3]  = '{16'h31A5, 3'b000, 0, 1, 0, 1, 0, 0, 0};
        vec[4]  = '{16'h41A5, 3'b001, 1, 1, 0, 0, 0, 0, 0};
        vec[5]  = '{16'h51A5, 3'b010, 1, 1, 0, 0, 0, 0, 0};
        vec[6]  = '{16'h61A5, 3'b010, 0, 1, 0, 1, 0, 0, 0};
        vec[7]  = '{16'h71A5, 3'b011, 1, 1, 0, 0, 0, 0, 0};
        vec[8]  = '{16'h81A5, 3'b011, 0, 1, 0, 1, 0, 0, 0};
        vec[9]  = '{16'h91A5, 3'b100, 0, 1, 0, 1, 0, 0, 0};
        vec[10] = '{16'hA1A5, 3'b101, 0, 1, 0, 1, 0, 0, 0};
        vec[11] = '{16'hB1A5, 3'b110, 0, 0, 0, 0, 0, 0, 0};
        vec[12] = '{16'hC1A5, 3'b111, 0, 0, 0, 0, 0, 0, 0};
        vec[13] = '{16'hD1A5, 3'b010, 1, 1, 1, 0, 0, 0, 0};
        vec[14] = '{16'hE1A5, 3'b000, 0, 0, 0, 0, 0, 0, 1};
        vec[15] = '{16'hF1A5, 3'b000, 0, 0, 0, 0, 0, 0, 1};

        rst = 1'b1; in_valid = 1'b1; in_instr = 16'h2E40;
        flush = 1'b0; wb_valid = 1'b0; wb_addr = '0; out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bundle", 32'(out_b), 32'd0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 4; r++) chk_cnt("rst_cnt", r, 0);
        tick();

        // Opcode table sweep
        for (int i = 0; i < 16; i++) begin
            send(vec[i].instr, 5);
            tick();
            if (vec[i].rw) wb(vec[i].rd ? 2'd2 : 2'd1);
            @(negedge clk);
            chk_cnt("vec_cnt", vec[i].rd ? 2 : 1, 0);
            chk("vec_stall", 32'(stall), 32'd0);
            tick();
        end

        // Back-to-back ADD r1 = r3 + r2, latency 1
        in_valid = 1'b1;
        in_instr = 16'h2E40;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(in_ready), 32'd1);
            if (k > 0) chk("b2b_out_valid", 32'(out_valid), 32'd1);
            if (k > 0) chk("b2b_dst", 32'(out_dst), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_out_valid", 32'(out_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("b2b_drained", 32'(out_valid), 32'd0);
        chk_cnt("b2b_cnt", 1, 3);
        tick();
        wb(2'd1); wb(2'd1); wb(2'd1);
        @(negedge clk);
        chk_cnt("b2b_retired", 1, 0);
        tick();
        send(16'h3205, 0);
        @(negedge clk);
        chk("addi_latency", 32'(out_valid), 32'd1);
        chk("addi_alu", 32'(out_alu_op), 32'd0);
        tick();
        wb(2'd2);

        // RAW: AND reading r1 waits for its retirement
        send(16'h2E40, 0);
        tick();
        in_valid = 1'b1;
        in_instr = 16'h5400;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("raw_stall", 32'(stall), 32'd1);
            chk("raw_ready", 32'(in_ready), 32'd0);
            tick();
        end
        wb_valid = 1'b1;
        wb_addr  = 2'd1;
        @(negedge clk);
        chk("raw_wb_ready", 32'(in_ready), 32'd1);
        chk("raw_wb_stall", 32'(stall), 32'd0);
        tick();
        wb_valid = 1'b0;
        in_valid = 1'b0;
        tick();
        wb(2'd0);
        @(negedge clk);
        chk_cnt("raw_cnt1", 1, 0);
        chk_cnt("raw_cnt0", 0, 0);
        tick();

        // Illegal opcode
        send(16'hF000, 0);
        @(negedge clk);
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_rw", 32'(out_reg_write), 32'd0);
        chk("ill_mw", 32'(out_mem_write), 32'd0);
        tick();
        @(negedge clk);
        for (int r = 0; r < 4; r++) chk_cnt("ill_cnt", r, 0);
        tick();

        // Inflight cap: three ADDI to r2, fourth waits
        in_valid = 1'b1;
        in_instr = 16'h3205;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("cap_ready", 32'(in_ready), 32'd1);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("cap_stall", 32'(stall), 32'd1);
            tick();
        end
        wb_valid = 1'b1;
        wb_addr  = 2'd2;
        @(negedge clk);
        chk_cnt("cap_full", 2, 3);
        chk("cap_wb_ready", 32'(in_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk_cnt("cap_refill", 2, 3);
        tick();
        wb(2'd2); wb(2'd2); wb(2'd2);

        // Flush a held LW
        out_ready = 1'b0;
        send(16'h0300, 0);
        @(negedge clk);
        chk("fl_held", 32'(out_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("fl_held2", 32'(out_valid), 32'd1);
        tick();
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = 16'h3105;
        @(negedge clk);
        chk("fl_block", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk_cnt("fl_cnt", 3, 0);
        tick();

        // Same-cycle dispatch and retire on r3
        send(16'h0300, 0);
        tick();
        send(16'h0300, 0);
        wb_valid = 1'b1;
        wb_addr  = 2'd3;
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        chk_cnt("same_cnt", 3, 1);
        tick();

        // Reset mid-stream with a held bundle and a pending write
        out_ready = 1'b0;
        send(16'h3105, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        for (int r = 0; r < 4; r++) chk_cnt("mid_rst_cnt", r, 0);

        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
